// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer with press/release pulses and auto-repeat.
// Each channel: two-flop synchroniser, IDLE/RISE/HELD/FALL FSM, repeat timer.
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_COUNT  = 16,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] switch_input,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int SW = $clog2(STABLE_COUNT);
  localparam int RW = $clog2(RMAX);

  localparam logic [SW-1:0] S_TOP = SW'(STABLE_COUNT - 1);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PER = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    HELD,
    FALL
  } state_t;

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  state_t          r_state    [CHANNELS];
  state_t          w_state_nx [CHANNELS];
  logic [SW-1:0]   r_scnt     [CHANNELS];
  logic [SW-1:0]   w_scnt_nx  [CHANNELS];
  logic [RW-1:0]   r_rcnt     [CHANNELS];
  logic [RW-1:0]   w_rcnt_nx  [CHANNELS];
  logic [CHANNELS-1:0] r_rarm;
  logic [CHANNELS-1:0] w_rarm_nx;
  logic [CHANNELS-1:0] w_due;

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_press;
  logic [CHANNELS-1:0] w_release;
  logic [CHANNELS-1:0] w_repeat;

  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_press;
  logic [CHANNELS-1:0] r_release;
  logic [CHANNELS-1:0] r_repeat;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_state_nx[c] = r_state[c];
      w_scnt_nx[c]  = r_scnt[c];
      w_rcnt_nx[c]  = r_rcnt[c];
      w_rarm_nx[c]  = r_rarm[c];
      w_press[c]    = 1'b0;
      w_release[c]  = 1'b0;
      w_repeat[c]   = 1'b0;
      // r_rarm selects the period once the first repeat has fired
      w_due[c] = (r_rcnt[c] == (r_rarm[c] ? R_PER : R_DLY));
      unique case (r_state[c])
        IDLE: begin
          w_rcnt_nx[c] = '0;
          w_rarm_nx[c] = 1'b0;
          if (r_sync2[c]) begin
            w_state_nx[c] = RISE;
            w_scnt_nx[c]  = S_ONE;
          end
        end
        RISE: begin
          if (!r_sync2[c]) begin
            w_state_nx[c] = IDLE;
            w_scnt_nx[c]  = '0;
          end else if (r_scnt[c] == S_TOP) begin
            w_state_nx[c] = HELD;
            w_scnt_nx[c]  = '0;
            w_rcnt_nx[c]  = '0;
            w_rarm_nx[c]  = 1'b0;
            w_press[c]    = 1'b1;
          end else begin
            w_scnt_nx[c] = r_scnt[c] + 1'b1;
          end
        end
        HELD: begin
          if (!r_sync2[c]) begin
            w_state_nx[c] = FALL;
            w_scnt_nx[c]  = S_ONE;
            // a due repeat is held back until the level is stable again
            if (!w_due[c])
              w_rcnt_nx[c] = r_rcnt[c] + 1'b1;
          end else if (w_due[c]) begin
            w_repeat[c]  = (REPEAT_EN != 0);
            w_rcnt_nx[c] = '0;
            w_rarm_nx[c] = 1'b1;
          end else begin
            w_rcnt_nx[c] = r_rcnt[c] + 1'b1;
          end
        end
        FALL: begin
          if (r_sync2[c]) begin
            w_state_nx[c] = HELD;
            w_scnt_nx[c]  = '0;
          end else if (r_scnt[c] == S_TOP) begin
            w_state_nx[c] = IDLE;
            w_scnt_nx[c]  = '0;
            w_rcnt_nx[c]  = '0;
            w_rarm_nx[c]  = 1'b0;
            w_release[c]  = 1'b1;
          end else begin
            w_scnt_nx[c] = r_scnt[c] + 1'b1;
          end
        end
      endcase
      w_level[c] = (w_state_nx[c] == HELD) ||
                   (w_state_nx[c] == FALL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_rarm    <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_repeat  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c] <= IDLE;
        r_scnt[c]  <= '0;
        r_rcnt[c]  <= '0;
      end
    end else begin
      r_sync1   <= switch_input;
      r_sync2   <= r_sync1;
      r_rarm    <= w_rarm_nx;
      r_level   <= w_level;
      r_press   <= w_press;
      r_release <= w_release;
      r_repeat  <= w_repeat;
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c] <= w_state_nx[c];
        r_scnt[c]  <= w_scnt_nx[c];
        r_rcnt[c]  <= w_rcnt_nx[c];
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_repeat  = r_repeat;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus random bouncing,
// every cycle compared against a run-length reference model.
module tb_debounce_bank;

  localparam int CH = 2;
  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] sw = '0;
  logic [CH-1:0] lvl, prs, rel, rpt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CH-1:0] m_s1, m_s2;
  logic [CH-1:0] m_lvl, m_prs, m_rel, m_rpt;
  int m_run [CH];
  int m_h   [CH];
  int m_tgt [CH];

  debounce_bank #(
    .CHANNELS(CH),
    .STABLE_COUNT(SC),
    .REPEAT_EN(1),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .switch_input(sw),
    .btn_level(lvl),
    .btn_press(prs),
    .btn_release(rel),
    .btn_repeat(rpt)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_s1  = '0;
    m_s2  = '0;
    m_lvl = '0;
    m_prs = '0;
    m_rel = '0;
    m_rpt = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0;
      m_h[c]   = 0;
      m_tgt[c] = RD;
    end
  endtask

  // Level flips after SC consecutive samples that disagree with it;
  // repeats count stable-held cycles since press or the last repeat.
  task automatic m_edge();
    logic [CH-1:0] smp;
    int hn;
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = sw;
    m_prs = '0;
    m_rel = '0;
    m_rpt = '0;
    for (int c = 0; c < CH; c++) begin
      if (m_lvl[c] && m_run[c] == 0) begin
        hn = m_h[c] + 1;
        if (hn == m_tgt[c]) begin
          if (smp[c]) begin
            m_rpt[c] = 1'b1;
            m_h[c]   = 0;
            m_tgt[c] = RP;
          end
        end else begin
          m_h[c] = hn;
        end
      end
      if (smp[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == SC) begin
          m_lvl[c] = ~m_lvl[c];
          m_run[c] = 0;
          if (m_lvl[c]) begin
            m_prs[c] = 1'b1;
            m_h[c]   = 0;
            m_tgt[c] = RD;
          end else begin
            m_rel[c] = 1'b1;
          end
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [CH-1:0] obs,
                     input logic [CH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) m_edge();
    #1;
    chk("level", lvl, m_lvl);
    chk("press", prs, m_prs);
    chk("release", rel, m_rel);
    chk("repeat", rpt, m_rpt);
  endtask

  // which: 0 press, 1 release, 2 repeat; n = -1 if the bound expires
  task automatic steps_to(input int which, input logic [CH-1:0] mask,
                          input int lim, output int n);
    logic [CH-1:0] s;
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      s = (which == 0) ? prs : (which == 1) ? rel : rpt;
      if ((s & mask) != '0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_level", lvl, '0);
    chk("rst_press", prs, '0);
    chk("rst_release", rel, '0);
    chk("rst_repeat", rpt, '0);
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int rep_at [$];
    logic [CH-1:0] exp_rel;
    m_reset();
    #12;
    chk("reset_level", lvl, '0);
    chk("reset_press", prs, '0);
    chk("reset_release", rel, '0);
    chk("reset_repeat", rpt, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    sw = 2'b01;
    steps_to(0, 2'b01, 20, n);
    chk_int("clean_press_lat", n, SC + 2);
    chk("clean_press_lvl", lvl, 2'b01);
    sw = 2'b00;
    steps_to(1, 2'b01, 20, n);
    chk_int("clean_rel_lat", n, SC + 2);
    idle(4);

    sw = 2'b01;
    idle(3);
    sw = 2'b00;
    idle(1);
    sw = 2'b01;
    steps_to(0, 2'b01, 20, n);
    chk_int("bounce_press_lat", n, SC + 2);

    idle(3);
    sw = 2'b00;
    idle(2);
    sw = 2'b01;
    steps_to(2, 2'b01, 40, n);
    chk_int("glitch_rep_delay", n + 5, RD + 2);
    sw = 2'b00;
    steps_to(1, 2'b01, 40, n);
    chk_int("glitch_rel_lat", n, SC + 2);
    idle(4);

    sw = 2'b10;
    steps_to(0, 2'b10, 20, n);
    chk_int("rep_press_lat", n, SC + 2);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (rpt[1]) rep_at.push_back(i);
    end
    chk_int("rep_count", rep_at.size(), 5);
    for (int k = 0; k < 5 && k < rep_at.size(); k++)
      chk_int("rep_time", rep_at[k], RD + k * RP);
    sw = 2'b00;
    steps_to(1, 2'b10, 20, n);
    chk_int("rep_rel_lat", n, SC + 2);
    idle(4);

    sw = 2'b01;
    steps_to(0, 2'b01, 20, n);
    idle(2);
    sw = 2'b10;
    steps_to(0, 2'b10, 20, n);
    chk_int("simul_lat", n, SC + 2);
    exp_rel = 2'b01;
    chk("simul_rel", rel, exp_rel);
    sw = 2'b00;
    idle(12);

    sw = 2'b01;
    steps_to(0, 2'b01, 20, n);
    sw = 2'b11;
    idle(3);
    do_reset();
    steps_to(0, 2'b11, 20, n);
    chk_int("post_rst_lat", n, SC + 2);
    chk("post_rst_both", prs, 2'b11);
    sw = 2'b00;
    idle(12);

    for (int blk = 0; blk < 60; blk++) begin
      if (blk == 31) do_reset();
      for (int i = 0; i < 50; i++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, 99) < ((blk % 2 == 1) ? 25 : 2))
            sw[c] = ~sw[c];
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent switch channels, legal range 1..16.
REQ-002 Parameter STABLE_COUNT, default 16: consecutive identical synchronised samples needed to accept a level change, legal range 2..65535.
REQ-003 Parameter REPEAT_EN, default 1: 1 enables auto-repeat pulses; 0 ties btn_repeat to 0.
REQ-004 Parameter REPEAT_DELAY, default 1000: cycles from a btn_press pulse to the first btn_repeat pulse, legal range 2..65535.
REQ-005 Parameter REPEAT_PERIOD, default 250: cycles between successive btn_repeat pulses, legal range 2..65535.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 switch_input  input  CHANNELS  raw, asynchronous, bouncing switch levels, one bit per channel.
REQ-009 btn_level  output  CHANNELS  debounced level per channel.
REQ-010 btn_press  output  CHANNELS  one-cycle pulse on each accepted 0->1 transition.
REQ-011 btn_release  output  CHANNELS  one-cycle pulse on each accepted 1->0 transition.
REQ-012 btn_repeat  output  CHANNELS  one-cycle auto-repeat pulse while a channel is held.

Function
REQ-013 Each channel SHALL pass switch_input through a two-flop synchroniser; only the second flop output (sync) feeds channel logic.
REQ-014 Each channel SHALL run an independent FSM with states IDLE, RISE, HELD and FALL, a stability counter sized for STABLE_COUNT-1, and a repeat counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-015 IDLE: sync=1 -> RISE with stability counter=1; otherwise the FSM stays in IDLE.
REQ-016 RISE: sync=0 -> IDLE with counter=0; sync=1 and counter=STABLE_COUNT-1 -> HELD; otherwise the counter increments.
REQ-017 HELD: sync=0 -> FALL with counter=1; otherwise the FSM stays in HELD.
REQ-018 FALL: sync=1 -> HELD with counter=0; sync=0 and counter=STABLE_COUNT-1 -> IDLE; otherwise the counter increments.
REQ-019 btn_level SHALL be 1 exactly in HELD and FALL; all outputs SHALL be registered.
REQ-020 btn_press SHALL pulse for one cycle on RISE->HELD; btn_release SHALL pulse for one cycle on FALL->IDLE; FALL<->HELD bounce SHALL produce no pulse.
REQ-021 Latency: if raw rises before edge k and stays high, btn_level and btn_press SHALL assert after edge k+1+STABLE_COUNT; falling latency is symmetric.
REQ-022 The repeat counter SHALL clear on entry to HELD from RISE, increment each HELD cycle, hold its value in FALL, and clear in IDLE.
REQ-023 With REPEAT_EN=1, btn_repeat SHALL pulse REPEAT_DELAY HELD-cycles after btn_press, then every REPEAT_PERIOD HELD-cycles, until the channel leaves HELD/FALL.
REQ-024 btn_press, btn_release and btn_repeat SHALL never assert in the same cycle on one channel; if a repeat is due in the same cycle as HELD->FALL, the repeat SHALL be suppressed.
REQ-025 Channels SHALL be fully independent; simultaneous events on any subset SHALL each produce their own pulses in the same cycle.
REQ-026 Counters SHALL never wrap: the stability counter tops out at STABLE_COUNT-1, and the repeat counter reloads on each repeat pulse.

Reset
REQ-027 rst_n=0 SHALL immediately force every synchroniser flop, FSM (IDLE), counter and output to 0, regardless of clk.
REQ-028 Reset asserted mid-press SHALL emit no btn_release; a raw level still high after reset release SHALL give btn_press STABLE_COUNT+2 edges later.

Verification (CHANNELS=2, STABLE_COUNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-029 Clean press: ch0 raw 0->1 before edge 0, held -> btn_level[0]=1 and btn_press[0] pulse after edge 5; no other pulses.
REQ-030 Bounce: ch0 raw high for 3 cycles, low for 1 cycle, then high -> no pulse until 4 consecutive high sync samples; press 6 edges after the final rise.
REQ-031 Auto-repeat: hold ch1 for 30 cycles after press -> btn_repeat[1] at press+10, +15, +20, +25, +30; release gives one btn_release[1] 6 edges after raw falls.
REQ-032 Release glitch: in HELD, ch0 raw low for 2 cycles, then high -> no btn_release; the repeat schedule is delayed by exactly the FALL cycles.
REQ-033 Reset mid-operation: assert rst_n=0 while ch0 is HELD and ch1 is in RISE -> all outputs 0 at once; after release with both raw high, both presses occur on the same cycle.
REQ-034 Simultaneous: ch0 released and ch1 pressed in the same cycle -> btn_release[0] and btn_press[1] assert together.
